// File: rtl/pipe_pkg.sv
// Shared types for the core's inter-stage pipeline registers.
//   pipe_state_t  : occupancy state of an elastic stage (EMPTY / BUSY / FULL)
//   stage_ctrl_t  : control field carried alongside each payload beat
//   PIPE_CTRL_W   : width of stage_ctrl_t, default control width of a stage
//   PIPE_DATA_W   : default payload width (readData + ALURes + writeReg, padded)
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } stage_ctrl_t;

  localparam int PIPE_CTRL_W = $bits(stage_ctrl_t);
  localparam int PIPE_DATA_W = 72;

  // Number of entries held in each state.
  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// A main entry drives the outputs; a skid entry catches the one beat that can
// arrive while the downstream stalls, so in_ready can come straight from a flop
// and still sustain one beat per cycle.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             drop both held entries and the current input beat
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_ctrl/in_data   upstream control bits and payload
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data main-entry control (0 on a bubble) and payload
//   occupancy         entries held, 0..2
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_p1, state_n;
  logic              in_ready_p1;
  logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p1;
  logic [DATA_W-1:0] main_data_p1, skid_data_p1;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid, bubble;

  assign in_ready  = in_ready_p1;
  assign out_valid = (state_p1 != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_p1;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_occupancy(state_p1);

  // A bubble must never commit, so control is masked by valid.
  assign out_ctrl = main_ctrl_p1 & {CTRL_W{out_valid}};
  assign out_data = main_data_p1;

  always_comb begin
    state_n        = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    bubble         = 1'b0;
    case (state_p1)
      ST_EMPTY: begin
        if (in_fire) begin
          state_n      = ST_BUSY;
          load_main_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && !out_fire) begin
          state_n   = ST_FULL;
          load_skid = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_n = ST_EMPTY;
          bubble  = 1'b1;
        end else if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          state_n        = ST_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // Stage register: state, handshake flop, main and skid entries
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1     <= ST_EMPTY;
      in_ready_p1  <= 1'b1;
      main_ctrl_p1 <= '0;
      main_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
    end else if (flush) begin
      state_p1     <= ST_EMPTY;
      in_ready_p1  <= 1'b1;
      main_ctrl_p1 <= '0;
      skid_ctrl_p1 <= '0;
      if (CLR_DATA) begin
        main_data_p1 <= '0;
        skid_data_p1 <= '0;
      end
    end else begin
      state_p1    <= state_n;
      in_ready_p1 <= (state_n != ST_FULL);
      if (load_main_in) begin
        main_ctrl_p1 <= in_ctrl;
        main_data_p1 <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_p1 <= skid_ctrl_p1;
        main_data_p1 <= skid_data_p1;
      end
      if (load_skid) begin
        skid_ctrl_p1 <= in_ctrl;
        skid_data_p1 <= in_data;
      end
      // Debug builds clear payloads once they leave, so stale data never shows.
      if (CLR_DATA) begin
        if (bubble) main_data_p1 <= '0;
        if (load_main_skid) skid_data_p1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [3:0]  in_ctrl;
  logic [71:0] in_data;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [3:0]  out_ctrl0, out_ctrl1;
  logic [71:0] out_data0, out_data1;
  logic [1:0]  occ0, occ1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  c;
    logic [71:0] d;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(72), .CTRL_W(4), .CLR_DATA(1'b0)) u0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occ0)
  );

  pipe_stage_elastic #(.DATA_W(72), .CTRL_W(4), .CLR_DATA(1'b1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occupancy(occ1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake/control outputs of both instances against the same expectation.
  task automatic chk_ctl(input string tag, input logic vld, input logic [3:0] ctrl,
                         input logic rdy, input logic [1:0] occ);
    chk({tag, ".vld0"}, 72'(out_valid0), 72'(vld));
    chk({tag, ".vld1"}, 72'(out_valid1), 72'(vld));
    chk({tag, ".ctl0"}, 72'(out_ctrl0), 72'(ctrl));
    chk({tag, ".ctl1"}, 72'(out_ctrl1), 72'(ctrl));
    chk({tag, ".rdy0"}, 72'(in_ready0), 72'(rdy));
    chk({tag, ".rdy1"}, 72'(in_ready1), 72'(rdy));
    chk({tag, ".occ0"}, 72'(occ0), 72'(occ));
    chk({tag, ".occ1"}, 72'(occ1), 72'(occ));
  endtask

  task automatic chk_data(input string tag, input logic [71:0] d);
    chk({tag, ".dat0"}, out_data0, d);
    chk({tag, ".dat1"}, out_data1, d);
  endtask

  task automatic send(input logic [3:0] c, input logic [71:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 4'h5; in_data = 72'h55;

    // 1: reset for two cycles with a beat offered
    tick();
    tick();
    chk_ctl("rst", 1'b0, 4'h0, 1'b1, 2'd0);
    chk_data("rst", 72'h0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk_ctl("idle", 1'b0, 4'h0, 1'b1, 2'd0);

    // 2: streaming, each beat visible one cycle after it is offered
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(4'(i), 72'(i));
      tick();
      chk_ctl("stream", 1'b1, 4'(i), 1'b1, 2'd1);
      chk_data("stream", 72'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_ctl("drain", 1'b0, 4'h0, 1'b1, 2'd0);

    // 3: backpressure fills the skid entry, third beat held upstream
    out_ready = 1'b0;
    send(4'h1, 72'hA);
    tick();
    chk_ctl("bp.a", 1'b1, 4'h1, 1'b1, 2'd1);
    chk_data("bp.a", 72'hA);
    send(4'h2, 72'hB);
    tick();
    chk_ctl("bp.full", 1'b1, 4'h1, 1'b0, 2'd2);
    chk_data("bp.full", 72'hA);
    send(4'h3, 72'hC);
    tick();
    chk_ctl("bp.hold", 1'b1, 4'h1, 1'b0, 2'd2);
    chk_data("bp.hold", 72'hA);
    out_ready = 1'b1;
    tick();
    chk_ctl("bp.b", 1'b1, 4'h2, 1'b1, 2'd1);
    chk_data("bp.b", 72'hB);
    tick();
    chk_ctl("bp.c", 1'b1, 4'h3, 1'b1, 2'd1);
    chk_data("bp.c", 72'hC);
    in_valid = 1'b0;
    tick();
    chk_ctl("bp.end", 1'b0, 4'h0, 1'b1, 2'd0);

    // 4: flush a full stage while a beat is offered
    out_ready = 1'b0;
    send(4'hF, 72'h11);
    tick();
    send(4'hF, 72'h22);
    tick();
    chk_ctl("fl.full", 1'b1, 4'hF, 1'b0, 2'd2);
    flush = 1'b1;
    send(4'hF, 72'hD);
    tick();
    chk_ctl("fl.empty", 1'b0, 4'h0, 1'b1, 2'd0);
    chk("fl.keep0", out_data0, 72'h11);
    chk("fl.clr1", out_data1, 72'h0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk_ctl("fl.stay", 1'b0, 4'h0, 1'b1, 2'd0);
    out_ready = 1'b1;
    send(4'h6, 72'h33);
    tick();
    chk_ctl("fl.next", 1'b1, 4'h6, 1'b1, 2'd1);
    chk_data("fl.next", 72'h33);
    in_valid = 1'b0;
    tick();

    // 5: reset wins over flush while full
    out_ready = 1'b0;
    send(4'h3, 72'h44);
    tick();
    send(4'h3, 72'h55);
    tick();
    chk_ctl("rf.full", 1'b1, 4'h3, 1'b0, 2'd2);
    reset = 1'b1; flush = 1'b1;
    tick();
    chk_ctl("rf", 1'b0, 4'h0, 1'b1, 2'd0);
    chk_data("rf", 72'h0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    // 6: random valid/ready/flush against a scoreboard FIFO
    for (int c = 0; c < 3000; c++) begin
      logic mvld, mrdy, ifire, ofire;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_ctrl   = 4'($urandom_range(0, 15));
      in_data   = {40'(c + 1), 32'($urandom())};
      mvld = (sb.size() != 0);
      mrdy = (sb.size() < 2);
      chk_ctl("rnd", mvld, mvld ? sb[0].c : 4'h0, mrdy, 2'(sb.size()));
      if (mvld) begin
        chk_data("rnd", sb[0].d);
      end else begin
        chk("rnd.bub1", out_data1, 72'h0);
      end
      ifire = in_valid & mrdy;
      ofire = mvld & out_ready;
      if (flush) begin
        sb.delete();
      end else begin
        if (ofire) void'(sb.pop_front());
        if (ifire) sb.push_back({in_ctrl, in_data});
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
